// File: rtl/uart_tx_fifo_if.sv
// Producer/UART-facing bundle of the transmit byte queue: write port, status and TX handshake.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    wr_data_i;
    logic          wr_en_i;
    logic          full_o;
    logic [CW-1:0] count_o;
    logic          ovf_o;
    logic [7:0]    tx_data_o;
    logic          tx_ready_o;
    logic          tx_ack_i;

    modport master (
        output wr_data_i, wr_en_i, tx_ack_i,
        input  full_o, count_o, ovf_o, tx_data_o, tx_ready_o
    );

    modport slave (
        input  wr_data_i, wr_en_i, tx_ack_i,
        output full_o, count_o, ovf_o, tx_data_o, tx_ready_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue in front of the UART TX: DEPTH-entry storage plus one output register.
// Optional newline expansion (LF -> CR,LF) when UART_TX_FIFO_CRLF_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        OUT_EMPTY = 2'd0,
        OUT_FULL  = 2'd1
`ifdef UART_TX_FIFO_CRLF_EN
        ,
        OUT_CR    = 2'd2
`endif
    } out_state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_r;
    logic          ovf_r;
    logic [7:0]    tx_data_r;
    logic          tx_ready_r;
    out_state_t    state_r;

    logic          push_s;
    logic          pop_s;
    logic          xfer_s;
    logic          have_s;
    logic [7:0]    head_s;
    logic [7:0]    data_n_s;
    out_state_t    state_n_s;
    logic [CW-1:0] count_n_s;

    // A write while full is dropped even if a pop frees a slot on the same edge.
    assign push_s    = bus.wr_en_i && !full_r;
    assign xfer_s    = tx_ready_r && bus.tx_ack_i;
    assign have_s    = (count_r != {CW{1'b0}});
    assign head_s    = mem_r[rd_ptr_r];
    assign count_n_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};

    assign bus.full_o     = full_r;
    assign bus.count_o    = count_r;
    assign bus.ovf_o      = ovf_r;
    assign bus.tx_data_o  = tx_data_r;
    assign bus.tx_ready_o = tx_ready_r;

    // Output stage next-state: load head on empty or on transfer, with no bubble between bytes.
    always_comb begin
        pop_s     = 1'b0;
        state_n_s = state_r;
        data_n_s  = tx_data_r;
        case (state_r)
            OUT_EMPTY, OUT_FULL: begin
                if ((state_r == OUT_EMPTY || xfer_s) && have_s) begin
`ifdef UART_TX_FIFO_CRLF_EN
                    if (head_s == 8'h0A) begin
                        data_n_s  = 8'h0D;
                        state_n_s = OUT_CR;
                    end else begin
                        data_n_s  = head_s;
                        pop_s     = 1'b1;
                        state_n_s = OUT_FULL;
                    end
`else
                    data_n_s  = head_s;
                    pop_s     = 1'b1;
                    state_n_s = OUT_FULL;
`endif
                end else if (xfer_s) begin
                    state_n_s = OUT_EMPTY;
                end else begin
                    state_n_s = state_r;
                end
            end
`ifdef UART_TX_FIFO_CRLF_EN
            OUT_CR: begin
                // LF stays queued (and counted) until its CR has been taken.
                if (xfer_s) begin
                    data_n_s  = 8'h0A;
                    pop_s     = 1'b1;
                    state_n_s = OUT_FULL;
                end else begin
                    state_n_s = OUT_CR;
                end
            end
`endif
            default: begin
                state_n_s = OUT_EMPTY;
            end
        endcase
    end

    // Storage array write port; contents are don't-care until counted.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data_i;
        end
    end

    // Pointers, occupancy, sticky overflow and the registered output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            ovf_r      <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_ready_r <= 1'b0;
            state_r    <= OUT_EMPTY;
        end else begin
            wr_ptr_r   <= push_s ? wr_ptr_r + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_r;
            rd_ptr_r   <= pop_s  ? rd_ptr_r + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_r;
            count_r    <= count_n_s;
            full_r     <= (count_n_s == CW'(DEPTH));
            ovf_r      <= ovf_r | (bus.wr_en_i && full_r);
            tx_data_r  <= data_n_s;
            tx_ready_r <= (state_n_s != OUT_EMPTY);
            state_r    <= state_n_s;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: queue-level reference model plus a byte-stream scoreboard.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
`ifdef UART_TX_FIFO_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
    uart_tx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes waiting in storage, the byte on offer, and the expected UART stream.
    logic [7:0] st_q [$];
    logic [7:0] exp_q [$];
    bit         m_valid = 1'b0;
    bit         m_cr    = 1'b0;
    bit         m_ovf   = 1'b0;
    logic [7:0] m_data  = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin : model
        bit xfer;
        bit push;
        if (!reset) begin
            st_q.delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_cr    = 1'b0;
            m_ovf   = 1'b0;
            m_data  = 8'h00;
        end else begin
            xfer = m_valid && bus.tx_ack_i;
            push = bus.wr_en_i && (st_q.size() < DEPTH);
            if (bus.wr_en_i && !push) m_ovf = 1'b1;
            if (m_cr && xfer) begin
                m_data = 8'h0A;
                void'(st_q.pop_front());
                m_cr = 1'b0;
            end else if ((!m_valid || xfer) && st_q.size() > 0) begin
                if (CRLF && st_q[0] == 8'h0A) begin
                    m_data = 8'h0D;
                    m_cr   = 1'b1;
                end else begin
                    m_data = st_q.pop_front();
                end
                m_valid = 1'b1;
            end else if (xfer) begin
                m_valid = 1'b0;
            end
            if (push) begin
                st_q.push_back(bus.wr_data_i);
                if (CRLF && bus.wr_data_i == 8'h0A) exp_q.push_back(8'h0D);
                exp_q.push_back(bus.wr_data_i);
            end
        end
    end

    // Monitor: status against the model every cycle, delivered bytes against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            check("count", int'(bus.count_o), st_q.size());
            check("full", int'(bus.full_o), int'(st_q.size() == DEPTH));
            check("ovf", int'(bus.ovf_o), int'(m_ovf));
            check("ready", int'(bus.tx_ready_o), int'(m_valid));
            check("data", int'(bus.tx_data_o), int'(m_data));
            if (bus.tx_ready_o && bus.tx_ack_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", int'(bus.tx_data_o), -1);
                end else begin
                    check("sb_data", int'(bus.tx_data_o), int'(exp_q.pop_front()));
                end
            end
        end else begin
            check("rst_ready", int'(bus.tx_ready_o), 0);
            check("rst_count", int'(bus.count_o), 0);
            check("rst_data", int'(bus.tx_data_o), 0);
        end
    end

    task automatic cyc(input bit we, input logic [7:0] d, input bit ack);
        bus.wr_en_i   = we;
        bus.wr_data_i = d;
        bus.tx_ack_i  = ack;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 8; i++) cyc(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = 8'h00;
        bus.tx_ack_i  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;

        // Single byte with the UART idle.
        cyc(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

        // Three bytes held, then single-cycle ack pulses.
        cyc(1'b1, 8'h41, 1'b0);
        cyc(1'b1, 8'h42, 1'b0);
        cyc(1'b1, 8'h43, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            cyc(1'b0, 8'h00, 1'b0);
        end
        drain();

        // Overfill, then a write colliding with a transfer while full.
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 8'($urandom) | 8'h80, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h7E, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        drain();

        // Newline handling.
        cyc(1'b1, 8'h61, 1'b1);
        cyc(1'b1, 8'h0A, 1'b1);
        cyc(1'b1, 8'h62, 1'b1);
        drain();

        // Reset asserted mid-drain, between clock edges.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("rst_now_ready", int'(bus.tx_ready_o), 0);
        check("rst_now_count", int'(bus.count_o), 0);
        check("rst_now_full", int'(bus.full_o), 0);
        check("rst_now_ovf", int'(bus.ovf_o), 0);
        check("rst_now_data", int'(bus.tx_data_o), 0);
        @(posedge clk);
        #2 reset = 1'b1;
        cyc(1'b1, 8'hA5, 1'b0);
        cyc(1'b1, 8'h5A, 1'b0);
        drain();

        // Random traffic with bursty writes, random acks and frequent line feeds.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom);
            if ((i / 300) % 2 == 0)
                cyc($urandom_range(0, 99) < 85, d, $urandom_range(0, 3) == 0);
            else
                cyc($urandom_range(0, 99) < 40, d, $urandom_range(0, 1) == 1);
        end
        drain();
        check("sb_leftover", exp_q.size(), 0);
        check("final_ready", int'(bus.tx_ready_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
